// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the shared-ALU arbiter: op codes and FSM states.
// No ports; imported by rr_pick and alu_share_arbiter.
package alu_share_arbiter_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports: req (pending requests), ptr (start index), gnt (one-hot winner),
//        gnt_idx (winner index), any (some request is pending).
module rr_pick
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      gnt_idx,
    output logic            any
);

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        // Scan from ptr upward with wrap; first pending request wins.
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = 3'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one AND/OR/XOR/ADD unit between NREQ requesters.
// Ports: clk, rst (async high); req_valid/req_ready/req_op/req_a/req_b per
//        requester (packed); rsp_valid/rsp_ready handshake with registered
//        rsp_id, rsp_data, rsp_carry, rsp_zero.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [2*NREQ-1:0]  req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2:0]         rsp_id,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_carry,
    output logic               rsp_zero
);

    localparam logic [2:0] LAST = 3'(NREQ - 1);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       rr_ptr;
    logic [NREQ-1:0]  gnt;
    logic [2:0]       gnt_idx;
    logic             any;
    logic             take;

    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   res;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        take      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (any) begin
                    req_ready = gnt;
                    take      = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_nxt = ST_IDLE;
            end
        endcase
        // The grant is combinational, so mask it while reset is held.
        if (rst) begin
            req_ready = '0;
            take      = 1'b0;
        end
    end

    assign rsp_valid = (state == ST_RESP);

    assign op = req_op[2*int'(gnt_idx) +: 2];
    assign a  = req_a[WIDTH*int'(gnt_idx) +: WIDTH];
    assign b  = req_b[WIDTH*int'(gnt_idx) +: WIDTH];

    // Bit WIDTH of res is the ADD carry; logic ops leave it clear.
    always_comb begin
        res = '0;
        unique case (op)
            OP_AND: res = {1'b0, a & b};
            OP_OR:  res = {1'b0, a | b};
            OP_XOR: res = {1'b0, a ^ b};
            OP_ADD: res = {1'b0, a} + {1'b0, b};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
        end else if (take) begin
            rr_ptr    <= (gnt_idx == LAST) ? 3'd0 : gnt_idx + 3'd1;
            rsp_id    <= gnt_idx;
            rsp_data  <= res[WIDTH-1:0];
            rsp_carry <= res[WIDTH];
            rsp_zero  <= (res[WIDTH-1:0] == '0);
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed vectors push expected
// responses; a negedge monitor pops and compares on each rsp handshake.
module tb_alu_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2:0]            rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_carry;
    logic                  rsp_zero;

    int checks = 0;
    int passed = 0;

    // Packed {id, carry, zero, data}
    logic [12:0] sb[$];

    alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [12:0] rsp(input int id, input logic c,
                                        input logic z, input logic [7:0] d);
        return {3'(id), c, z, d};
    endfunction

    // Monitor: a response shown with rsp_ready high is consumed next edge.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {19'd0, rsp_id, rsp_carry, rsp_zero,
                    rsp_data}, 32'hFFFF_FFFF);
            end else begin
                chk("rsp", {19'd0, rsp_id, rsp_carry, rsp_zero, rsp_data},
                    {19'd0, sb.pop_front()});
            end
        end
    end

    task automatic set_req(input int i, input logic [1:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        req_op[2*i +: 2] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (rsp_valid && n < 50) begin
            tick();
            n++;
        end
        if (rsp_valid) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Single requester i; expects its grant, then rsp_valid next cycle.
    task automatic issue_one(input int i, input logic [1:0] op,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic [12:0] exp);
        wait_idle();
        set_req(i, op, a, b);
        req_valid = 4'(1 << i);
        #1;
        chk("single_grant", 32'(req_ready), 32'(1 << i));
        sb.push_back(exp);
        tick();
        req_valid = '0;
        chk("latency_valid", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'hF;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #2;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_outs", {26'd0, rsp_valid, rsp_id, rsp_carry, rsp_zero},
            32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;

        // Single requester ADD
        issue_one(2, 2'b11, 8'h12, 8'h34, rsp(2, 1'b0, 1'b0, 8'h46));

        // Arithmetic corners
        issue_one(0, 2'b11, 8'hFF, 8'h01, rsp(0, 1'b1, 1'b1, 8'h00));
        issue_one(1, 2'b00, 8'hF0, 8'h3C, rsp(1, 1'b0, 1'b0, 8'h30));
        issue_one(2, 2'b01, 8'hF0, 8'h3C, rsp(2, 1'b0, 1'b0, 8'hFC));
        issue_one(3, 2'b10, 8'hF0, 8'h3C, rsp(3, 1'b0, 1'b0, 8'hCC));
        wait_idle();

        // Round-robin: ptr is 0 after requester 3; expect 0,1,2,3,0
        set_req(0, 2'b11, 8'h10, 8'h20);
        set_req(1, 2'b00, 8'hFF, 8'h0F);
        set_req(2, 2'b01, 8'h00, 8'h00);
        set_req(3, 2'b10, 8'hA5, 8'h5A);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            int w;
            w = k % 4;
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1 << w));
            case (w)
                0: sb.push_back(rsp(0, 1'b0, 1'b0, 8'h30));
                1: sb.push_back(rsp(1, 1'b0, 1'b0, 8'h0F));
                2: sb.push_back(rsp(2, 1'b0, 1'b1, 8'h00));
                default: sb.push_back(rsp(3, 1'b0, 1'b0, 8'hFF));
            endcase
            tick();
            chk("rr_resp_noready", 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = '0;
        wait_idle();

        // Backpressure: ptr is 1; requesters 1 and 2 valid
        rsp_ready = 1'b0;
        set_req(1, 2'b01, 8'h01, 8'h02);
        set_req(2, 2'b11, 8'h80, 8'h80);
        req_valid = 4'b0110;
        #1;
        chk("bp_grant", 32'(req_ready), 32'b0010);
        sb.push_back(rsp(1, 1'b0, 1'b0, 8'h03));
        tick();
        req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold", {19'd0, rsp_valid, rsp_id, rsp_carry, rsp_zero,
                rsp_data}, {19'd0, 1'b1, 3'd1, 1'b0, 1'b0, 8'h03});
            chk("bp_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_next_grant", 32'(req_ready), 32'b0100);
        sb.push_back(rsp(2, 1'b1, 1'b1, 8'h00));
        tick();
        req_valid = '0;
        wait_idle();

        // Valid dropped in RESP: ptr is 3; issue 0 with stall
        rsp_ready = 1'b0;
        set_req(0, 2'b00, 8'h0F, 8'hF0);
        set_req(1, 2'b11, 8'h01, 8'h01);
        set_req(3, 2'b11, 8'h7F, 8'h01);
        req_valid = 4'b0001;
        #1;
        chk("drop_grant0", 32'(req_ready), 32'b0001);
        sb.push_back(rsp(0, 1'b0, 1'b1, 8'h00));
        tick();
        req_valid = 4'b1010;
        chk("drop_resp_ready", 32'(req_ready), 32'd0);
        tick();
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        tick();
        chk("drop_grant3", 32'(req_ready), 32'b1000);
        sb.push_back(rsp(3, 1'b0, 1'b0, 8'h80));
        tick();
        req_valid = '0;
        wait_idle();

        // Reset mid-RESP
        rsp_ready = 1'b0;
        set_req(2, 2'b10, 8'h55, 8'h0F);
        req_valid = 4'b0100;
        #1;
        chk("mid_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'hF;
        chk("mid_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {26'd0, rsp_valid, rsp_id, rsp_carry, rsp_zero},
            32'd0);
        chk("mid_rst_data", 32'(rsp_data), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'b0001);
        sb.push_back(rsp(0, 1'b0, 1'b1, 8'h00));
        tick();
        req_valid = '0;
        wait_idle();
        tick();
        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
